irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Interrupt controller directly upstream of the status-register/stack-pointer stage.
- Latches peripheral interrupt requests, masks and prioritises them, and accepts one at an instruction boundary when the global I flag is set.
- On acceptance it drives `irq_det`, which clears I and starts the vector/PC-push sequence. It drives `irq_ret` during RETI so that I is set again.
- Tracks nesting depth and the AVR rule that one instruction executes after RETI before another interrupt is accepted.

Parameters:
- N_IRQ, 8: number of interrupt sources (1..8).
- EDGE_MASK, 8'hFF: per-source select; bit=1 means rising-edge latched, bit=0 means level-sensitive.
- VEC_BASE, 16'h0002: word address of the source-0 vector.
- VEC_STRIDE, 16'h0002: word distance between consecutive vectors.

Ports:
- clock  in  1  master clock
- reset  in  1  active-high synchronous reset
- irq_src  in  N_IRQ  raw interrupt request lines
- sr_if  in  1  status register I flag
- inst_bound  in  1  strobe: current instruction completes this cycle
- reti_exec  in  1  decoder strobe: RETI in its SREG-update cycle, coincident with tim_sr_en
- mm_ie_we  in  1  write strobe for the enable register
- mm_ifr_we  in  1  write strobe for the flag register (write-one-to-clear)
- mm_io_wdata  in  8  memory-mapped I/O write data
- irq_det  out  1  interrupt accepted, one-cycle pulse
- irq_ret  out  1  interrupt return
- irq_vec  out  16  vector word address of the accepted source
- irq_ie  out  8  enable register; bits at and above N_IRQ read 0
- irq_ifr  out  8  pending flags; bits at and above N_IRQ read 0
- irq_busy  out  1  nesting depth is non-zero

Behaviour:
- Reset (synchronous, at the clock edge while reset=1):
  - irq_ie=0, edge flags=0, previous-sample register=0.
  - depth=0, state=IDLE.
  - irq_det=0, irq_vec=VEC_BASE.
  - reset overrides every other input in the same cycle, including mid-ACCEPT: the pending irq_det pulse is dropped.
- Flags:
  - Edge source i: flag set when irq_src[i]=1 and the previous sample=0.
  - Edge flag cleared by mm_ifr_we with wdata[i]=1, or by acceptance of source i.
  - A set and a clear in the same cycle: set wins.
  - Level source i: irq_ifr[i] equals the (synchronised) irq_src[i]; writes to its flag are ignored.
- Enable register: mm_ie_we loads irq_ie <= wdata (bits at and above N_IRQ forced 0).
- Request and priority:
  - req = irq_ifr & irq_ie.
  - The lowest set index wins, fixed priority.
- State machine, 3 states:
  - IDLE → ACCEPT when req≠0 & sr_if & inst_bound & depth≠15.
    - Registered at that edge: winner index, irq_vec = VEC_BASE + idx*VEC_STRIDE (16-bit, wraps mod 2^16), edge flag of the winner cleared.
  - ACCEPT:
    - irq_det=1 for exactly this cycle; depth++; next state IDLE.
    - New acceptance is inhibited in this cycle even if inst_bound=1.
  - IDLE → HOLD on reti_exec when depth≠0; depth-- at the same edge.
  - HOLD → IDLE on the first inst_bound (the instruction after RETI). No acceptance at that boundary.
  - reti_exec with depth=0: no state change, no underflow.
- irq_ret:
  - Combinational, irq_ret = reti_exec, zero latency.
  - This lets I be set in the same tim_sr_en cycle, and applies whether or not depth≠0.
- irq_busy = (depth≠0), registered.
- Nesting:
  - Acceptance is allowed at any depth<15 if software has set I again.
  - At depth=15, requests are held pending.
- irq_vec holds its value until the next acceptance.
- If sr_if drops, or the enable bit clears, while in IDLE before a boundary: no acceptance; the flag stays set.

Optional Feature:
- IRQ_SYNC_EN defined:
  - Each irq_src bit passes through a 2-flop synchroniser (reset 0) before edge detection and level use.
  - Adds 2 cycles of source-to-flag latency.
- IRQ_SYNC_EN undefined:
  - irq_src is sampled directly; the flag sets at the first edge where the rising edge is seen.

Test Plan:
- Reset, then irq_ie=8'h01, sr_if=1, one-cycle pulse on irq_src[0], inst_bound=1 → irq_ifr[0]=1. Then irq_det pulses 1 cycle, irq_vec=16'h0002, irq_ifr[0]=0, irq_busy=1.
- irq_ie=8'hFF, edges on sources 5 and 2 together, boundary → vector 16'h0006 (source 2) first. Source 5 stays pending and is accepted at a later boundary once sr_if=1 again: vector 16'h000C.
- In service (depth=1), reti_exec pulse → irq_ret=1 same cycle, depth=0. A pending request is not accepted at the next inst_bound, and is accepted at the boundary after that.
- mm_ifr_we with wdata=8'h01 in the same cycle as a new edge on source 0 → flag remains 1 (set wins). A write without an edge → flag 0.
- Level source (EDGE_MASK bit=0) held high with sr_if=0 → no irq_det. Raise sr_if → accepted. Write-one-to-clear has no effect while the line is high.
- Assert reset during the ACCEPT cycle → irq_det=0 the next cycle, depth=0, irq_ie=0, irq_vec=16'h0002. With IRQ_SYNC_EN, the source-to-flag delay measures 2 extra cycles.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller feeding the status-register/stack-pointer stage.
// Latches and masks peripheral requests, selects the lowest pending index and
// accepts it at an instruction boundary when I is set. Tracks nesting depth
// and the one-instruction hold after RETI.
//
// Ports:
//   clock, reset      master clock, active-high synchronous reset
//   irq_src           raw request lines (N_IRQ wide)
//   sr_if             status register I flag
//   inst_bound        current instruction completes this cycle
//   reti_exec         RETI in its SREG-update cycle
//   mm_ie_we          enable register write strobe
//   mm_ifr_we         flag register write strobe (write-one-to-clear)
//   mm_io_wdata       memory-mapped write data
//   irq_det           one-cycle acceptance pulse
//   irq_ret           interrupt return, combinational copy of reti_exec
//   irq_vec           vector word address of the accepted source
//   irq_ie, irq_ifr   enable and pending registers (bits >= N_IRQ read 0)
//   irq_busy          nesting depth is non-zero
//
// Build option: define IRQ_SYNC_EN to pass each source through a 2-flop
// synchroniser before edge detection and level use.
module irq_ctrl #(
    parameter int unsigned N_IRQ      = 8,
    parameter logic [7:0]  EDGE_MASK  = 8'hFF,
    parameter logic [15:0] VEC_BASE   = 16'h0002,
    parameter logic [15:0] VEC_STRIDE = 16'h0002
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_src,
    input  logic             sr_if,
    input  logic             inst_bound,
    input  logic             reti_exec,
    input  logic             mm_ie_we,
    input  logic             mm_ifr_we,
    input  logic [7:0]       mm_io_wdata,
    output logic             irq_det,
    output logic             irq_ret,
    output logic [15:0]      irq_vec,
    output logic [7:0]       irq_ie,
    output logic [7:0]       irq_ifr,
    output logic             irq_busy
);

    localparam int unsigned DEPTH_W   = 4;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = 4'd15;
    localparam logic [7:0]  SRC_MASK  = 8'((16'd1 << N_IRQ) - 16'd1);
    localparam logic [7:0]  EDGE_BITS = EDGE_MASK & SRC_MASK;
    localparam logic [7:0]  LEVEL_BITS = ~EDGE_MASK & SRC_MASK;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t               state;
    logic [DEPTH_W-1:0]   depth;
    logic [7:0]           src_raw;
    logic [7:0]           src_s;
    logic [7:0]           prev;
    logic [7:0]           req;
    logic [2:0]           win_idx;
    logic [7:0]           win_hot;
    logic [15:0]          vec_next;
    logic                 reti_go;
    logic                 take;
    logic [7:0]           rise;
    logic [7:0]           clr;
    logic [7:0]           ifr_next;

    assign src_raw = 8'(irq_src) & SRC_MASK;

`ifdef IRQ_SYNC_EN
    logic [7:0] sync1;
    logic [7:0] sync2;

    // Two-flop synchroniser on every source line
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= src_raw;
            sync2 <= sync1;
        end
    end

    assign src_s = sync2;
`else
    assign src_s = src_raw;
`endif

    // Fixed priority: lowest pending and enabled index wins
    always_comb begin
        req     = irq_ifr & irq_ie;
        win_idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                win_idx = 3'(i);
            end
        end
        win_hot  = 8'd1 << win_idx;
        vec_next = VEC_BASE + 16'(win_idx) * VEC_STRIDE;
    end

    // RETI takes precedence over acceptance in the same IDLE cycle
    assign reti_go = (state == IDLE) && reti_exec && (depth != '0);
    assign take    = (state == IDLE) && !reti_go && (req != '0) && sr_if
                     && inst_bound && (depth != DEPTH_MAX);

    // Edge flags: a new rising edge beats any clear in the same cycle;
    // level flags just follow the sampled line
    always_comb begin
        rise     = src_s & ~prev;
        clr      = (mm_ifr_we ? mm_io_wdata : 8'd0) | (take ? win_hot : 8'd0);
        ifr_next = ((rise | (irq_ifr & ~clr)) & EDGE_BITS) | (src_s & LEVEL_BITS);
    end

    assign irq_ret = reti_exec;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            depth    <= '0;
            prev     <= '0;
            irq_det  <= 1'b0;
            irq_vec  <= VEC_BASE;
            irq_ie   <= '0;
            irq_ifr  <= '0;
            irq_busy <= 1'b0;
        end else begin
            prev    <= src_s;
            irq_ifr <= ifr_next;
            irq_det <= 1'b0;
            if (mm_ie_we) begin
                irq_ie <= mm_io_wdata & SRC_MASK;
            end
            case (state)
                IDLE: begin
                    if (reti_go) begin
                        state    <= HOLD;
                        depth    <= depth - 4'd1;
                        irq_busy <= (depth != 4'd1);
                    end else if (take) begin
                        state   <= ACCEPT;
                        irq_det <= 1'b1;
                        irq_vec <= vec_next;
                    end
                end
                ACCEPT: begin
                    state    <= IDLE;
                    depth    <= depth + 4'd1;
                    irq_busy <= 1'b1;
                end
                HOLD: begin
                    // The instruction after RETI always completes unpreempted
                    if (inst_bound) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: directed scenarios plus a randomized run compared
// against a cycle-level behavioural model. Source 7 is configured level
// sensitive, all others rising-edge latched.
module tb_irq_ctrl;

    localparam logic [7:0]  EM = 8'h7F;
    localparam logic [15:0] VB = 16'h0002;
    localparam logic [15:0] VS = 16'h0002;
`ifdef IRQ_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  irq_src = '0;
    logic        sr_if = 1'b0;
    logic        inst_bound = 1'b0;
    logic        reti_exec = 1'b0;
    logic        mm_ie_we = 1'b0;
    logic        mm_ifr_we = 1'b0;
    logic [7:0]  mm_io_wdata = '0;
    logic        irq_det;
    logic        irq_ret;
    logic [15:0] irq_vec;
    logic [7:0]  irq_ie;
    logic [7:0]  irq_ifr;
    logic        irq_busy;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    logic [7:0]  m_flag = '0;
    logic [7:0]  m_prev = '0;
    logic [7:0]  m_ie = '0;
    int          m_depth = 0;
    bit          m_det = 0;
    logic [15:0] m_vec = VB;
    bit          m_accepting = 0;
    bit          m_after_reti = 0;
    logic [7:0]  hist[$];

    irq_ctrl #(
        .N_IRQ(8), .EDGE_MASK(EM), .VEC_BASE(VB), .VEC_STRIDE(VS)
    ) dut (
        .clock(clock), .reset(reset), .irq_src(irq_src), .sr_if(sr_if),
        .inst_bound(inst_bound), .reti_exec(reti_exec), .mm_ie_we(mm_ie_we),
        .mm_ifr_we(mm_ifr_we), .mm_io_wdata(mm_io_wdata), .irq_det(irq_det),
        .irq_ret(irq_ret), .irq_vec(irq_vec), .irq_ie(irq_ie),
        .irq_ifr(irq_ifr), .irq_busy(irq_busy)
    );

    always #5 clock = ~clock;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step;
        logic [7:0] seen, nflag;
        int idx;
        bit take, reti_go;
        if (reset) begin
            m_flag = '0; m_prev = '0; m_ie = '0; m_depth = 0; m_det = 0;
            m_vec = VB; m_accepting = 0; m_after_reti = 0;
            hist.delete();
            for (int k = 0; k < SYNC; k++) hist.push_back(8'd0);
            return;
        end
        if (SYNC == 0) seen = irq_src;
        else begin
            seen = hist[0];
            hist.delete(0);
            hist.push_back(irq_src);
        end
        idx = lowest(m_flag & m_ie);
        reti_go = !m_accepting && !m_after_reti && reti_exec && m_depth > 0;
        take = !m_accepting && !m_after_reti && idx >= 0 && sr_if && inst_bound
               && m_depth < 15 && !reti_go;
        for (int i = 0; i < 8; i++) begin
            if (!EM[i]) nflag[i] = seen[i];
            else if (seen[i] && !m_prev[i]) nflag[i] = 1'b1;
            else if ((mm_ifr_we && mm_io_wdata[i]) || (take && i == idx)) nflag[i] = 1'b0;
            else nflag[i] = m_flag[i];
        end
        m_det = take;
        if (take) m_vec = VB + 16'(idx) * VS;
        if (m_accepting) m_depth++;
        else if (reti_go) begin m_depth--; m_after_reti = 1; end
        else if (m_after_reti && inst_bound) m_after_reti = 0;
        m_accepting = take;
        m_prev = seen;
        m_flag = nflag;
        if (mm_ie_we) m_ie = mm_io_wdata;
    endtask

    task automatic tick;
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        total++; if (irq_det !== 1'b0) begin bad++; $display("FAIL reset_det got=%0b want=0", irq_det); end
        total++; if (irq_vec !== 16'h0002) begin bad++; $display("FAIL reset_vec got=%h want=0002", irq_vec); end
        total++; if (irq_ie !== 8'h00) begin bad++; $display("FAIL reset_ie got=%h want=00", irq_ie); end
        total++; if (irq_ifr !== 8'h00) begin bad++; $display("FAIL reset_ifr got=%h want=00", irq_ifr); end
        total++; if (irq_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", irq_busy); end
    endtask

    task automatic test_basic;
        mm_ie_we = 1'b1; mm_io_wdata = 8'h01; tick(); mm_ie_we = 1'b0;
        sr_if = 1'b1; irq_src = 8'h01; tick(); irq_src = 8'h00;
        repeat (SYNC) tick();
        total++; if (irq_ifr !== 8'h01) begin bad++; $display("FAIL basic_flag got=%h want=01", irq_ifr); end
        inst_bound = 1'b1; tick();
        total++; if (irq_det !== 1'b1) begin bad++; $display("FAIL basic_det got=%0b want=1", irq_det); end
        total++; if (irq_vec !== 16'h0002) begin bad++; $display("FAIL basic_vec got=%h want=0002", irq_vec); end
        total++; if (irq_ifr !== 8'h00) begin bad++; $display("FAIL basic_clr got=%h want=00", irq_ifr); end
        inst_bound = 1'b0; sr_if = 1'b0; tick();
        total++; if (irq_det !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%0b want=0", irq_det); end
        total++; if (irq_busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%0b want=1", irq_busy); end
    endtask

    task automatic test_reti;
        mm_ie_we = 1'b1; mm_io_wdata = 8'hFF; tick(); mm_ie_we = 1'b0;
        irq_src = 8'h02; tick(); irq_src = 8'h00;
        repeat (SYNC) tick();
        reti_exec = 1'b1; #1;
        total++; if (irq_ret !== 1'b1) begin bad++; $display("FAIL reti_ret got=%0b want=1", irq_ret); end
        tick(); reti_exec = 1'b0; #1;
        total++; if (irq_ret !== 1'b0) begin bad++; $display("FAIL reti_ret_low got=%0b want=0", irq_ret); end
        total++; if (irq_busy !== 1'b0) begin bad++; $display("FAIL reti_busy got=%0b want=0", irq_busy); end
        sr_if = 1'b1; inst_bound = 1'b1; tick();
        total++; if (irq_det !== 1'b0) begin bad++; $display("FAIL reti_hold got=%0b want=0", irq_det); end
        tick();
        total++; if (irq_det !== 1'b1) begin bad++; $display("FAIL reti_next_det got=%0b want=1", irq_det); end
        total++; if (irq_vec !== 16'h0004) begin bad++; $display("FAIL reti_next_vec got=%h want=0004", irq_vec); end
        inst_bound = 1'b0; sr_if = 1'b0; tick();
    endtask

    task automatic test_priority;
        irq_src = 8'h24; tick(); irq_src = 8'h00;
        repeat (SYNC) tick();
        total++; if (irq_ifr !== 8'h24) begin bad++; $display("FAIL prio_flags got=%h want=24", irq_ifr); end
        sr_if = 1'b1; inst_bound = 1'b1; tick();
        total++; if (irq_det !== 1'b1 || irq_vec !== 16'h0006) begin bad++; $display("FAIL prio_first got=%0b/%h want=1/0006", irq_det, irq_vec); end
        inst_bound = 1'b0; sr_if = 1'b0; tick();
        total++; if (irq_ifr !== 8'h20) begin bad++; $display("FAIL prio_pending got=%h want=20", irq_ifr); end
        sr_if = 1'b1; inst_bound = 1'b1; tick();
        total++; if (irq_det !== 1'b1 || irq_vec !== 16'h000C) begin bad++; $display("FAIL prio_second got=%0b/%h want=1/000c", irq_det, irq_vec); end
        inst_bound = 1'b0; sr_if = 1'b0; tick();
        total++; if (irq_ifr !== 8'h00) begin bad++; $display("FAIL prio_empty got=%h want=00", irq_ifr); end
    endtask

    task automatic test_w1c;
        irq_src = 8'h01;
        repeat (SYNC) tick();
        mm_ifr_we = 1'b1; mm_io_wdata = 8'h01; tick(); mm_ifr_we = 1'b0;
        irq_src = 8'h00;
        total++; if (irq_ifr[0] !== 1'b1) begin bad++; $display("FAIL w1c_set_wins got=%0b want=1", irq_ifr[0]); end
        mm_ifr_we = 1'b1; tick(); mm_ifr_we = 1'b0;
        total++; if (irq_ifr[0] !== 1'b0) begin bad++; $display("FAIL w1c_clear got=%0b want=0", irq_ifr[0]); end
    endtask

    task automatic test_level;
        bit seen_det;
        irq_src = 8'h80; seen_det = 0;
        repeat (SYNC + 3) begin tick(); if (irq_det) seen_det = 1; end
        total++; if (seen_det !== 1'b0) begin bad++; $display("FAIL level_masked_by_i got=%0b want=0", seen_det); end
        total++; if (irq_ifr[7] !== 1'b1) begin bad++; $display("FAIL level_flag got=%0b want=1", irq_ifr[7]); end
        mm_ifr_we = 1'b1; mm_io_wdata = 8'h80; tick(); mm_ifr_we = 1'b0;
        total++; if (irq_ifr[7] !== 1'b1) begin bad++; $display("FAIL level_w1c got=%0b want=1", irq_ifr[7]); end
        sr_if = 1'b1; inst_bound = 1'b1; tick();
        total++; if (irq_det !== 1'b1 || irq_vec !== 16'h0010) begin bad++; $display("FAIL level_accept got=%0b/%h want=1/0010", irq_det, irq_vec); end
        inst_bound = 1'b0; sr_if = 1'b0; irq_src = 8'h00;
        repeat (SYNC + 1) tick();
        total++; if (irq_ifr[7] !== 1'b0) begin bad++; $display("FAIL level_drop got=%0b want=0", irq_ifr[7]); end
    endtask

    task automatic test_reset_accept;
        irq_src = 8'h08; tick(); irq_src = 8'h00;
        repeat (SYNC) tick();
        sr_if = 1'b1; inst_bound = 1'b1; tick();
        total++; if (irq_det !== 1'b1 || irq_vec !== 16'h0008) begin bad++; $display("FAIL rst_acc_pre got=%0b/%h want=1/0008", irq_det, irq_vec); end
        reset = 1'b1; inst_bound = 1'b0; sr_if = 1'b0; tick(); reset = 1'b0;
        total++; if (irq_det !== 1'b0) begin bad++; $display("FAIL rst_acc_det got=%0b want=0", irq_det); end
        total++; if (irq_busy !== 1'b0) begin bad++; $display("FAIL rst_acc_busy got=%0b want=0", irq_busy); end
        total++; if (irq_ie !== 8'h00) begin bad++; $display("FAIL rst_acc_ie got=%h want=00", irq_ie); end
        total++; if (irq_vec !== 16'h0002) begin bad++; $display("FAIL rst_acc_vec got=%h want=0002", irq_vec); end
        tick();
        total++; if (irq_busy !== 1'b0) begin bad++; $display("FAIL rst_acc_depth got=%0b want=0", irq_busy); end
    endtask

    task automatic test_depth_limit;
        int n_acc;
        bit seen_det;
        n_acc = 0;
        mm_ie_we = 1'b1; mm_io_wdata = 8'h01; tick(); mm_ie_we = 1'b0;
        for (int k = 0; k < 15; k++) begin
            irq_src = 8'h01; tick(); irq_src = 8'h00;
            repeat (SYNC) tick();
            sr_if = 1'b1; inst_bound = 1'b1; tick();
            if (irq_det) n_acc++;
            inst_bound = 1'b0; sr_if = 1'b0; tick();
        end
        total++; if (n_acc != 15) begin bad++; $display("FAIL depth_fill got=%0d want=15", n_acc); end
        irq_src = 8'h01; tick(); irq_src = 8'h00;
        repeat (SYNC) tick();
        sr_if = 1'b1; inst_bound = 1'b1; seen_det = 0;
        repeat (3) begin tick(); if (irq_det) seen_det = 1; end
        total++; if (seen_det !== 1'b0) begin bad++; $display("FAIL depth_max_det got=%0b want=0", seen_det); end
        total++; if (irq_ifr[0] !== 1'b1) begin bad++; $display("FAIL depth_max_pending got=%0b want=1", irq_ifr[0]); end
        inst_bound = 1'b0; reti_exec = 1'b1; tick(); reti_exec = 1'b0;
        inst_bound = 1'b1; tick();
        total++; if (irq_det !== 1'b0) begin bad++; $display("FAIL depth_hold got=%0b want=0", irq_det); end
        tick();
        total++; if (irq_det !== 1'b1 || irq_vec !== 16'h0002) begin bad++; $display("FAIL depth_resume got=%0b/%h want=1/0002", irq_det, irq_vec); end
        inst_bound = 1'b0; sr_if = 1'b0; tick();
    endtask

    task automatic test_random;
        reset = 1'b1; tick(); reset = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) irq_src = irq_src ^ (8'd1 << $urandom_range(0, 7));
            sr_if      = ($urandom_range(0, 1) == 1);
            inst_bound = ($urandom_range(0, 1) == 1);
            mm_ie_we   = ($urandom_range(0, 15) == 0);
            mm_ifr_we  = ($urandom_range(0, 7) == 0);
            mm_io_wdata = 8'($urandom);
            reti_exec  = !inst_bound && !m_accepting && !m_after_reti && ($urandom_range(0, 5) == 0);
            #1;
            total++; if (irq_ret !== reti_exec) begin bad++; $display("FAIL rnd_ret c=%0d got=%0b want=%0b", c, irq_ret, reti_exec); end
            tick();
            total++; if (irq_det !== m_det) begin bad++; $display("FAIL rnd_det c=%0d got=%0b want=%0b", c, irq_det, m_det); end
            total++; if (irq_vec !== m_vec) begin bad++; $display("FAIL rnd_vec c=%0d got=%h want=%h", c, irq_vec, m_vec); end
            total++; if (irq_ifr !== m_flag) begin bad++; $display("FAIL rnd_ifr c=%0d got=%h want=%h", c, irq_ifr, m_flag); end
            total++; if (irq_ie !== m_ie) begin bad++; $display("FAIL rnd_ie c=%0d got=%h want=%h", c, irq_ie, m_ie); end
            total++; if (irq_busy !== (m_depth != 0)) begin bad++; $display("FAIL rnd_busy c=%0d got=%0b want=%0b", c, irq_busy, (m_depth != 0)); end
        end
        reti_exec = 1'b0; inst_bound = 1'b0; sr_if = 1'b0;
        mm_ie_we = 1'b0; mm_ifr_we = 1'b0; irq_src = 8'h00;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reti();
        test_priority();
        test_w1c();
        test_level();
        test_reset_accept();
        test_depth_limit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
